// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator arbiter slice.
package calc_pkg;

  localparam int unsigned OPND_W = 8;
  localparam int unsigned RES_W  = 27;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    else                grant = valid;
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one calculator datapath between two requesters; one operation in flight,
// response tagged with the requester id and held until accepted.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned CALC_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*OPND_W-1:0]   req_a,
  input  logic [2*OPND_W-1:0]   req_b,
  input  logic [3:0]            req_op,
  output logic [OPND_W-1:0]     calc_a,
  output logic [OPND_W-1:0]     calc_b,
  output logic [1:0]            calc_op,
  input  logic [RES_W-1:0]      calc_s,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [RES_W-1:0]      resp_s,
  output logic                  resp_err
);

  localparam logic [3:0] LAT_M1 = 4'(CALC_LAT - 1);

  state_t              state;
  logic                last_grant;
  logic [3:0]          cnt;
  logic [1:0]          grant;
  logic                accept;
  logic                accept_id;
  logic [OPND_W-1:0]   sel_a;
  logic [OPND_W-1:0]   sel_b;
  op_t                 sel_op;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    req_ready = (state == IDLE) ? (grant & req_valid) : '0;
    accept    = |req_ready;
    accept_id = req_ready[1];
    sel_a     = accept_id ? req_a[2*OPND_W-1:OPND_W] : req_a[OPND_W-1:0];
    sel_b     = accept_id ? req_b[2*OPND_W-1:OPND_W] : req_b[OPND_W-1:0];
    sel_op    = op_t'(accept_id ? req_op[3:2] : req_op[1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      calc_a     <= '0;
      calc_b     <= '0;
      calc_op    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_s     <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= accept_id;
            resp_id    <= accept_id;
            // Divide by zero bypasses the datapath so calc_* keep their previous values.
            if (sel_op == OP_DIV && sel_b == '0) begin
              resp_err   <= 1'b1;
              resp_s     <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              calc_a  <= sel_a;
              calc_b  <= sel_b;
              calc_op <= sel_op;
              cnt     <= LAT_M1;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            resp_s     <= calc_s;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter: one instance at latency 1, one at latency 3.
module tb_calc_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  v1, rdy1, v3, rdy3;
  logic [15:0] a1, b1, a3, b3;
  logic [3:0]  op1, op3;
  logic [7:0]  ca1, cb1, ca3, cb3;
  logic [1:0]  cop1, cop3;
  logic [26:0] cs1, cs3, rs1, rs3;
  logic        rv1, rr1, rid1, rerr1;
  logic        rv3, rr3, rid3, rerr3;

  int n_cmp = 0;
  int n_err = 0;

  // Reference calculator driven by the DUT's operand outputs.
  function automatic logic [26:0] calc_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] op);
    case (op)
      2'b00:   return 27'(a) + 27'(b);
      2'b01:   return 27'(a) - 27'(b);
      2'b10:   return 27'(a) * 27'(b);
      default: return (b == 8'd0) ? '1 : 27'(a / b);
    endcase
  endfunction

  assign cs1 = calc_model(ca1, cb1, cop1);
  assign cs3 = calc_model(ca3, cb3, cop3);

  calc_arbiter #(.CALC_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1),
    .req_a(a1), .req_b(b1), .req_op(op1),
    .calc_a(ca1), .calc_b(cb1), .calc_op(cop1), .calc_s(cs1),
    .resp_valid(rv1), .resp_ready(rr1), .resp_id(rid1), .resp_s(rs1), .resp_err(rerr1)
  );

  calc_arbiter #(.CALC_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
    .req_a(a3), .req_b(b3), .req_op(op3),
    .calc_a(ca3), .calc_b(cb3), .calc_op(cop3), .calc_s(cs3),
    .resp_valid(rv3), .resp_ready(rr3), .resp_id(rid3), .resp_s(rs3), .resp_err(rerr3)
  );

  int ta0[5] = '{10, 50, 12, 255, 5};
  int tb0[5] = '{3, 8, 12, 16, 9};
  int to0[5] = '{0, 1, 2, 3, 1};
  int ts0[5] = '{13, 42, 144, 15, 134217724};
  int te0[5] = '{0, 0, 0, 0, 0};
  int ta1[5] = '{1, 255, 100, 0, 9};
  int tb1[5] = '{1, 255, 7, 0, 0};
  int to1[5] = '{0, 2, 3, 0, 3};
  int ts1[5] = '{2, 65025, 14, 0, 0};
  int te1[5] = '{0, 0, 0, 0, 1};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    v1 = '0; a1 = '0; b1 = '0; op1 = '0; rr1 = 1'b1;
    v3 = '0; a3 = '0; b3 = '0; op3 = '0; rr3 = 1'b1;
    #3;
    n_cmp++;
    if ({rdy1, rdy3} !== 4'b0) begin
      $display("FAIL reset_req_ready: got %b expected 0000", {rdy1, rdy3}); n_err++;
    end
    n_cmp++;
    if ({rv1, rid1, rerr1, rs1} !== 30'd0) begin
      $display("FAIL reset_resp1: got %h expected 0", {rv1, rid1, rerr1, rs1}); n_err++;
    end
    n_cmp++;
    if ({rv3, rid3, rerr3, rs3} !== 30'd0) begin
      $display("FAIL reset_resp3: got %h expected 0", {rv3, rid3, rerr3, rs3}); n_err++;
    end
    n_cmp++;
    if ({ca1, cb1, cop1, ca3, cb3, cop3} !== 36'd0) begin
      $display("FAIL reset_calc: got %h expected 0", {ca1, cb1, cop1, ca3, cb3, cop3}); n_err++;
    end
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_tie;
    a1 = {8'd200, 8'd3}; b1 = {8'd50, 8'd5}; op1 = {2'b01, 2'b10}; v1 = 2'b11;
    #1;
    n_cmp++;
    if (rdy1 !== 2'b01) begin
      $display("FAIL tie_first_grant: got %b expected 01", rdy1); n_err++;
    end
    tick;
    v1 = 2'b10;
    n_cmp++;
    if ({rv1, rdy1} !== 3'b000) begin
      $display("FAIL tie_busy: got %b expected 000", {rv1, rdy1}); n_err++;
    end
    n_cmp++;
    if ({ca1, cb1, cop1} !== {8'd3, 8'd5, 2'b10}) begin
      $display("FAIL tie_calc_ops: got %h expected %h", {ca1, cb1, cop1}, {8'd3, 8'd5, 2'b10}); n_err++;
    end
    tick;
    n_cmp++;
    if ({rv1, rid1, rerr1, rs1} !== {1'b1, 1'b0, 1'b0, 27'd15}) begin
      $display("FAIL tie_resp0: got %h expected %h", {rv1, rid1, rerr1, rs1}, {1'b1, 1'b0, 1'b0, 27'd15}); n_err++;
    end
    tick;
    n_cmp++;
    if ({rv1, rdy1} !== 3'b010) begin
      $display("FAIL tie_second_grant: got %b expected 010", {rv1, rdy1}); n_err++;
    end
    tick;
    v1 = 2'b00;
    tick;
    n_cmp++;
    if ({rv1, rid1, rerr1, rs1} !== {1'b1, 1'b1, 1'b0, 27'd150}) begin
      $display("FAIL tie_resp1: got %h expected %h", {rv1, rid1, rerr1, rs1}, {1'b1, 1'b1, 1'b0, 27'd150}); n_err++;
    end
    tick;
    n_cmp++;
    if (rv1 !== 1'b0) begin
      $display("FAIL tie_resp_done: got %b expected 0", rv1); n_err++;
    end
  endtask

  task automatic test_single_add;
    a1 = {8'd0, 8'd100}; b1 = {8'd0, 8'd27}; op1 = 4'b0000; v1 = 2'b01;
    #1;
    n_cmp++;
    if (rdy1 !== 2'b01) begin
      $display("FAIL add_grant: got %b expected 01", rdy1); n_err++;
    end
    tick;
    v1 = 2'b00;
    n_cmp++;
    if ({rv1, rdy1} !== 3'b000) begin
      $display("FAIL add_busy: got %b expected 000", {rv1, rdy1}); n_err++;
    end
    tick;
    n_cmp++;
    if ({rv1, rid1, rerr1, rs1} !== {1'b1, 1'b0, 1'b0, 27'd127}) begin
      $display("FAIL add_resp: got %h expected %h", {rv1, rid1, rerr1, rs1}, {1'b1, 1'b0, 1'b0, 27'd127}); n_err++;
    end
    tick;
    n_cmp++;
    if (rv1 !== 1'b0) begin
      $display("FAIL add_resp_done: got %b expected 0", rv1); n_err++;
    end
  endtask

  task automatic test_div0;
    a1 = {8'd9, 8'd0}; b1 = {8'd0, 8'd0}; op1 = 4'b1100; v1 = 2'b10;
    #1;
    n_cmp++;
    if (rdy1 !== 2'b10) begin
      $display("FAIL div0_grant: got %b expected 10", rdy1); n_err++;
    end
    tick;
    v1 = 2'b00;
    n_cmp++;
    if ({rv1, rid1, rerr1, rs1} !== {1'b1, 1'b1, 1'b1, 27'd0}) begin
      $display("FAIL div0_resp: got %h expected %h", {rv1, rid1, rerr1, rs1}, {1'b1, 1'b1, 1'b1, 27'd0}); n_err++;
    end
    n_cmp++;
    if ({ca1, cb1, cop1} !== {8'd100, 8'd27, 2'b00}) begin
      $display("FAIL div0_calc_held: got %h expected %h", {ca1, cb1, cop1}, {8'd100, 8'd27, 2'b00}); n_err++;
    end
    tick;
    n_cmp++;
    if (rv1 !== 1'b0) begin
      $display("FAIL div0_resp_done: got %b expected 0", rv1); n_err++;
    end
  endtask

  task automatic test_backpressure;
    rr3 = 1'b0;
    a3 = {8'd0, 8'd7}; b3 = {8'd0, 8'd6}; op3 = 4'b0010; v3 = 2'b01;
    #1;
    n_cmp++;
    if (rdy3 !== 2'b01) begin
      $display("FAIL bp_grant: got %b expected 01", rdy3); n_err++;
    end
    tick;
    v3 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({rv3, rdy3} !== 3'b000) begin
        $display("FAIL bp_busy_%0d: got %b expected 000", i, {rv3, rdy3}); n_err++;
      end
      tick;
    end
    n_cmp++;
    if ({rv3, rid3, rerr3, rs3} !== {1'b1, 1'b0, 1'b0, 27'd42}) begin
      $display("FAIL bp_resp: got %h expected %h", {rv3, rid3, rerr3, rs3}, {1'b1, 1'b0, 1'b0, 27'd42}); n_err++;
    end
    v3 = 2'b10;
    for (int i = 0; i < 5; i++) begin
      a3 = {8'(i + 1), 8'(i * 3)}; b3 = {8'(i), 8'(200 - i)}; op3 = 4'(i);
      tick;
      n_cmp++;
      if ({rv3, rid3, rerr3, rs3, rdy3} !== {1'b1, 1'b0, 1'b0, 27'd42, 2'b00}) begin
        $display("FAIL bp_hold_%0d: got %h expected %h", i, {rv3, rid3, rerr3, rs3, rdy3},
                 {1'b1, 1'b0, 1'b0, 27'd42, 2'b00}); n_err++;
      end
    end
    rr3 = 1'b1;
    tick;
    n_cmp++;
    if ({rv3, rdy3} !== 3'b010) begin
      $display("FAIL bp_release: got %b expected 010", {rv3, rdy3}); n_err++;
    end
    v3 = 2'b00;
  endtask

  task automatic test_reset_mid_busy;
    a3 = {8'd0, 8'd10}; b3 = {8'd0, 8'd2}; op3 = 4'b0000; v3 = 2'b01;
    #1;
    tick;
    v3 = 2'b00;
    n_cmp++;
    if ({rv3, rdy3} !== 3'b000) begin
      $display("FAIL rmb_busy: got %b expected 000", {rv3, rdy3}); n_err++;
    end
    tick;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rv3, rdy3, ca3, cb3, cop3} !== 21'd0) begin
      $display("FAIL rmb_reset_outputs: got %h expected 0", {rv3, rdy3, ca3, cb3, cop3}); n_err++;
    end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      n_cmp++;
      if (rv3 !== 1'b0) begin
        $display("FAIL rmb_no_resp_%0d: got %b expected 0", i, rv3); n_err++;
      end
    end
    v3 = 2'b11;
    #1;
    n_cmp++;
    if (rdy3 !== 2'b01) begin
      $display("FAIL rmb_tie_grant: got %b expected 01", rdy3); n_err++;
    end
    v3 = 2'b00;
    #1;
  endtask

  task automatic test_continuous;
    int idx0, idx1, w, g, exs, exe;
    logic timed_out;
    idx0 = 0; idx1 = 0; timed_out = 1'b0;
    rr3 = 1'b1;
    a3 = {8'(ta1[0]), 8'(ta0[0])}; b3 = {8'(tb1[0]), 8'(tb0[0])};
    op3 = {2'(to1[0]), 2'(to0[0])}; v3 = 2'b11;
    #1;
    for (int k = 0; k < 10 && !timed_out; k++) begin
      g = k % 2;
      w = 0;
      while (rdy3 == 2'b00 && w < 20) begin tick; w++; end
      if (w == 20) begin
        n_cmp++; n_err++; timed_out = 1'b1;
        $display("FAIL cont_grant_timeout_%0d: got no grant expected grant within 20 cycles", k);
      end else begin
        n_cmp++;
        if (rdy3 !== ((g == 1) ? 2'b10 : 2'b01)) begin
          $display("FAIL cont_grant_%0d: got %b expected requester %0d", k, rdy3, g); n_err++;
        end
        exs = (g == 1) ? ts1[idx1 % 5] : ts0[idx0 % 5];
        exe = (g == 1) ? te1[idx1 % 5] : te0[idx0 % 5];
        if (rdy3[1]) idx1++; else idx0++;
        tick;
        a3 = {8'(ta1[idx1 % 5]), 8'(ta0[idx0 % 5])};
        b3 = {8'(tb1[idx1 % 5]), 8'(tb0[idx0 % 5])};
        op3 = {2'(to1[idx1 % 5]), 2'(to0[idx0 % 5])};
        v3 = {(idx1 < 5), (idx0 < 5)};
        w = 0;
        while (!rv3 && w < 20) begin tick; w++; end
        n_cmp++;
        if (w == 20) begin
          $display("FAIL cont_resp_timeout_%0d: got no resp_valid expected one within 20 cycles", k);
          n_err++; timed_out = 1'b1;
        end else if ({rid3, rerr3, rs3} !== {1'(g), 1'(exe), 27'(exs)}) begin
          $display("FAIL cont_resp_%0d: got id=%0d err=%0d s=%0d expected id=%0d err=%0d s=%0d",
                   k, rid3, rerr3, rs3, g, exe, exs); n_err++;
        end
        tick;
      end
    end
    v3 = 2'b00;
  endtask

  initial begin
    test_reset;
    test_tie;
    test_single_add;
    test_div0;
    test_backpressure;
    test_reset_mid_busy;
    test_continuous;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Two-port round-robin arbiter and sequencer that shares one `calculadora` datapath (8-bit operands A/B, 2-bit op, 27-bit result S) between two requesters. It accepts one operation at a time over a valid/ready handshake and holds the operands stable on the datapath for the configured latency. It then captures the result and returns it, tagged with the requester id, over a back-pressurable response channel. It sits between the system's operation sources and the single calculator instance.

## Interface
- `CALC_LAT`, default 1: cycles the datapath needs from stable operands to valid S; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 2: per-requester request valid; bit i is requester i.
- `req_ready` output 2: per-requester accept; at most one bit high.
- `req_a`, `req_b` input 2x8: per-requester operands, packed `[i*8 +: 8]`.
- `req_op` input 2x2: per-requester op, packed `[i*2 +: 2]`. Encoding: 00 add, 01 sub, 10 mul, 11 div.
- `calc_a`, `calc_b` output 8: operands to the calculator.
- `calc_op` output 2: op to the calculator.
- `calc_s` input 27: calculator result.
- `resp_valid` output 1: response valid.
- `resp_ready` input 1: response accept.
- `resp_id` output 1: requester the response belongs to.
- `resp_s` output 27: result.
- `resp_err` output 1: 1 = divide by zero; `resp_s` is 0 when set.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` is high for the arbitration winner only, and only when that requester's `req_valid` is high.
  - Winner rule: if only one requester is valid, it wins. If both are valid, the requester not in `last_grant` wins.
- Accept occurs when `req_valid[i] & req_ready[i]`. On accept:
  - capture a, b, op and id into internal registers;
  - set `last_grant` = i.
- After accept, the next state depends on the captured request:
  - if op = 11 and b = 0: go directly to RESP with `resp_err`=1 and `resp_s`=0;
  - otherwise: go to BUSY and load the latency counter with `CALC_LAT`-1.
- BUSY:
  - `calc_a`/`calc_b`/`calc_op` are driven from the captured registers and are stable for the whole state.
  - The counter decrements each cycle.
  - In the cycle the counter is 0, `calc_s` is registered into `resp_s`, and the FSM goes to RESP.
- RESP:
  - `resp_valid`=1; `resp_id`, `resp_s` and `resp_err` are held stable.
  - On `resp_valid & resp_ready`, go to IDLE.
  - Both `req_ready` bits are 0 throughout BUSY and RESP.
- `calc_*` outputs hold the last captured values outside BUSY. They are not zeroed.
- Reset values:
  - all outputs 0; `resp_valid`=0, `req_ready`=0;
  - counter 0;
  - `last_grant`=1, so requester 0 wins the first tie.
- Reset mid-operation: any in-flight request is dropped with no response. Requesters must re-issue.

## Timing
- Accept at edge T.
- BUSY occupies cycles T+1 .. T+`CALC_LAT`.
- `resp_valid` rises at cycle T+`CALC_LAT`+1.
- Divide-by-zero: `resp_valid` rises at T+1 and the datapath is not used.
- With `resp_ready` held high, the response completes in 1 cycle. IDLE follows, and the next accept is possible one cycle later.
- Minimum spacing between accepts is therefore `CALC_LAT`+2 cycles.
- `req_ready` is combinational from `req_valid`, state and `last_grant`. All other outputs are registered.
- `resp_ready` low holds RESP indefinitely. No input change may alter any `resp_*` output.
- A `req_valid` that drops before acceptance is not latched.
- No fairness memory beyond one bit. Under continuous requests from both requesters, grants strictly alternate.

## Structure
- Shared package `calc_pkg`:
  - `op_t` enum (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`);
  - constants `OPND_W`=8, `RES_W`=27;
  - `state_t` enum for IDLE/BUSY/RESP.
- Sub-module `rr_arb2`: inputs valid[1:0] and last_grant; outputs a one-hot grant. It is purely combinational.
- The FSM, counter and capture registers live in `calc_arbiter`.

## Test plan
- Single add: requester 0 sends A=100, B=27, op=00 at T with `CALC_LAT`=1. Required: `resp_valid` at T+2 with `resp_id`=0, `resp_s`=127, `resp_err`=0.
- Tie after reset: both valid at the same cycle, requester 0 with 3*5 (op 10) and requester 1 with 200-50 (op 01). Required: requester 0 is granted first and returns 15; requester 1 is granted next and returns 150.
- Divide by zero: requester 1 sends A=9, B=0, op=11. Required: `resp_valid` one cycle after accept, `resp_err`=1, `resp_s`=0, `calc_*` outputs unchanged.
- Back-pressure: `CALC_LAT`=3, `resp_ready` held low for 5 cycles. Required: all `resp_*` outputs stable, `req_ready`=00 throughout. Release `resp_ready` and the FSM returns to IDLE the next cycle.
- Reset mid-BUSY: assert `rst` during BUSY. Required: immediately `resp_valid`=0, `req_ready`=00, and the FSM in IDLE. No response is ever issued for the dropped request, and the next tie goes to requester 0.
- Continuous load: both requesters valid for 10 operations. Required: grants alternate 0,1,0,1,... and results match the golden model for each operation.
